// File: rtl/pwm_capture.sv
// PWM/servo pulse capture with an Avalon-MM slave for HIGH_TIME, PERIOD, STATUS, TIMEOUT.
// Ports: clk, reset (async high), avs_* register bus, pwm_in (async); irq when PWM_CAPTURE_IRQ_EN is defined.
module pwm_capture #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic [31:0] TIMEOUT_RESET = 32'd2500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        pwm_in
`ifdef PWM_CAPTURE_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam logic [31:0] MAX = '1;

  typedef enum logic {IDLE, MEAS} state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sync;
  logic        s, s_d, rise, edge_s;
  logic [31:0] period_cnt, high_cnt, idle_cnt;
  logic [31:0] high_time, period, timeout;
  logic        valid, tmo, ovf, irq_en;
  logic        load, latch, tmo_hit;
  logic        wr_status, wr_timeout;

  assign s      = sync[SYNC_STAGES-1];
  assign rise   = s & ~s_d;
  assign edge_s = s ^ s_d;

  assign wr_status  = avs_write && (avs_address == 2'd2);
  assign wr_timeout = avs_write && (avs_address == 2'd3);

  assign tmo_hit = (timeout != '0) && (idle_cnt == timeout);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      s_d  <= s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // A timeout abandons any measurement in progress.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    latch    = 1'b0;
    if (tmo_hit) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: if (rise) begin
          load     = 1'b1;
          state_nx = MEAS;
        end
        MEAS: if (rise) begin
          load  = 1'b1;
          latch = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (load) begin
      period_cnt <= 32'd1;
      high_cnt   <= 32'd1;
    end else if (state == MEAS) begin
      if (period_cnt != MAX) period_cnt <= period_cnt + 32'd1;
      if (s && high_cnt != MAX) high_cnt <= high_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     idle_cnt <= '0;
    else if (edge_s || wr_timeout) idle_cnt <= '0;
    else if (idle_cnt != MAX)      idle_cnt <= idle_cnt + 32'd1;
  end

  // Set events outrank a simultaneous write-1-to-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_time <= '0;
      period    <= '0;
      valid     <= 1'b0;
      tmo       <= 1'b0;
      ovf       <= 1'b0;
      timeout   <= TIMEOUT_RESET;
    end else begin
      if (tmo_hit) begin
        high_time <= '0;
        period    <= '0;
      end else if (latch) begin
        high_time <= high_cnt;
        period    <= period_cnt;
      end
      if (latch)                             valid <= 1'b1;
      else if (tmo_hit)                      valid <= 1'b0;
      else if (wr_status && avs_writedata[0]) valid <= 1'b0;
      if (tmo_hit)                           tmo <= 1'b1;
      else if (wr_status && avs_writedata[1]) tmo <= 1'b0;
      if (latch && (period_cnt == MAX || high_cnt == MAX))
        ovf <= 1'b1;
      else if (wr_status && avs_writedata[2])
        ovf <= 1'b0;
      if (wr_timeout) timeout <= avs_writedata;
    end
  end

`ifdef PWM_CAPTURE_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_status) irq_en <= avs_writedata[8];
      irq <= valid & irq_en;
    end
  end

  logic unused_wd;
  assign unused_wd = ^{avs_writedata[31:9], avs_writedata[7:3]};
`else
  assign irq_en = 1'b0;

  logic unused_wd;
  assign unused_wd = ^{avs_writedata[31:8], avs_writedata[7:3]};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      unique case (avs_address)
        2'd0: avs_readdata <= high_time;
        2'd1: avs_readdata <= period;
        2'd2: avs_readdata <= {23'd0, irq_en, 5'd0, ovf, tmo, valid};
        2'd3: avs_readdata <= timeout;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: timestamp-based model checked every cycle plus literal expectations.
// Drives pwm waveforms and Avalon-MM reads/writes; polls registers whenever the bus is free.
module tb_pwm_capture;

  localparam int          S    = 2;
  localparam logic [31:0] TRST = 32'd2500000;
`ifdef PWM_CAPTURE_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        pwm_in;
`ifdef PWM_CAPTURE_IRQ_EN
  logic        irq;
`endif

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  pwm_capture #(
    .SYNC_STAGES  (S),
    .TIMEOUT_RESET(TRST)
  ) dut (
    .clk          (clk),
    .reset        (rst),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_readdata (avs_readdata),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .pwm_in       (pwm_in)
`ifdef PWM_CAPTURE_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  initial forever #5 clk = ~clk;

  // Model: s lags pwm_in by S samples; measurements come from edge timestamps.
  logic        pw [0:S];
  longint      cyc = 0;
  longint      t_rise, t_fall, t_edge;
  bit          fresh;
  logic [31:0] m_high, m_period, m_timeout, exp_rd;
  logic        m_valid, m_tmo, m_ovf, m_irqen, exp_irq;

  function automatic logic [31:0] regval(input logic [1:0] a);
    case (a)
      2'd0:    return m_high;
      2'd1:    return m_period;
      2'd2:    return {23'd0, m_irqen, 5'd0, m_ovf, m_tmo, m_valid};
      default: return m_timeout;
    endcase
  endfunction

  initial forever begin
    logic sv, sp, rs, fl, fire, wst, wto, nv, nt, novf;
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int i = 0; i <= S; i++) pw[i] = 1'b0;
      t_rise = -1; t_fall = -1; fresh = 1'b1;
      m_high = '0; m_period = '0; m_timeout = TRST;
      m_valid = 0; m_tmo = 0; m_ovf = 0; m_irqen = 0;
      exp_rd = '0; exp_irq = 1'b0;
    end else begin
      cyc++;
      if (fresh) begin t_edge = cyc - 1; fresh = 1'b0; end
      sv = pw[S-1]; sp = pw[S];
      rs = sv & ~sp; fl = ~sv & sp;
      fire = (m_timeout != 0) &&
             (cyc - 1 - t_edge == longint'(m_timeout));
      wst = avs_write && avs_address == 2'd2;
      wto = avs_write && avs_address == 2'd3;
      if (avs_read) exp_rd = regval(avs_address);
      exp_irq = m_valid & m_irqen;
      nv = m_valid; nt = m_tmo; novf = m_ovf;
      if (wst) begin
        if (avs_writedata[0]) nv = 1'b0;
        if (avs_writedata[1]) nt = 1'b0;
        if (avs_writedata[2]) novf = 1'b0;
      end
      if (fire) begin
        nv = 1'b0; nt = 1'b1;
        m_high = '0; m_period = '0; t_rise = -1;
      end else if (rs) begin
        if (t_rise >= 0) begin
          m_period = 32'(cyc - t_rise);
          m_high = 32'(((t_fall >= 0) ? t_fall : cyc) - t_rise);
          nv = 1'b1;
        end
        t_rise = cyc; t_fall = -1;
      end else if (fl && t_rise >= 0 && t_fall < 0) begin
        t_fall = cyc;
      end
      if (rs || fl || wto) t_edge = cyc;
      if (wto) m_timeout = avs_writedata;
      if (wst && HAS_IRQ) m_irqen = avs_writedata[8];
      m_valid = nv; m_tmo = nt; m_ovf = novf;
      for (int i = S; i > 0; i--) pw[i] = pw[i-1];
      pw[0] = pwm_in;
    end
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      checks++;
      if (avs_readdata !== exp_rd) begin
        failures++;
        $display("FAIL readdata t=%0t got 0x%08h want 0x%08h",
                 $time, avs_readdata, exp_rd);
      end
`ifdef PWM_CAPTURE_IRQ_EN
      checks++;
      if (irq !== exp_irq) begin
        failures++;
        $display("FAIL irq t=%0t got %b want %b", $time, irq, exp_irq);
      end
`endif
    end
  end

  logic       pwm    = 1'b0;
  logic [1:0] poll_a = 2'd0;

  task automatic step(input logic wr, input logic [1:0] a,
                      input logic [31:0] wd);
    pwm_in        = pwm;
    avs_write     = wr;
    avs_read      = ~wr;
    avs_address   = a;
    avs_writedata = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic poll(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, poll_a, 32'd0);
      poll_a = poll_a + 2'd1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1'b1, a, d);
  endtask

  // Write STATUS with wd at cycle wr_at of the waveform (-1: none).
  task automatic wave(input int hi, input int lo, input int reps,
                      input int wr_at, input logic [31:0] wd);
    int k = 0;
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi + lo; i++) begin
        pwm = (i < hi);
        if (k == wr_at) step(1'b1, 2'd2, wd);
        else begin
          step(1'b0, poll_a, 32'd0);
          poll_a = poll_a + 2'd1;
        end
        k++;
      end
    end
  endtask

  task automatic expect_rd(input logic [1:0] a, input logic [31:0] exp,
                           input string nm);
    step(1'b0, a, 32'd0);
    checks++;
    if (avs_readdata !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, avs_readdata, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    pwm_in = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
    avs_address = 2'd0; avs_writedata = '0;
    #1 started = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    expect_rd(2'd0, 32'd0, "rst_high");
    expect_rd(2'd1, 32'd0, "rst_period");
    expect_rd(2'd2, 32'd0, "rst_status");
    expect_rd(2'd3, TRST, "rst_timeout");

    wave(100, 400, 3, -1, 32'd0);
    expect_rd(2'd0, 32'd100, "pwm_high");
    expect_rd(2'd1, 32'd500, "pwm_period");
    expect_rd(2'd2, 32'd1, "pwm_status");

    wr(2'd2, 32'h100);
    expect_rd(2'd2, HAS_IRQ ? 32'h101 : 32'h1, "irq_en_rw");
    wr(2'd2, 32'h0);

    wave(100, 400, 1, S, 32'h1);
    expect_rd(2'd2, 32'd1, "w1c_same_cycle");
    wave(100, 400, 1, S + 1, 32'h1);
    expect_rd(2'd2, 32'd0, "w1c_next_cycle");

    wave(1500, 18500, 1, -1, 32'd0);
    wave(1500, 100, 1, -1, 32'd0);
    expect_rd(2'd0, 32'd1500, "servo_high");
    expect_rd(2'd1, 32'd20000, "servo_period");
    expect_rd(2'd2, 32'd1, "servo_status");

    wr(2'd3, 32'd1000);
    poll(1200);
    expect_rd(2'd2, 32'd2, "tmo_status");
    expect_rd(2'd0, 32'd0, "tmo_high");
    expect_rd(2'd1, 32'd0, "tmo_period");
    expect_rd(2'd3, 32'd1000, "tmo_timeout");
    wave(100, 400, 1, -1, 32'd0);
    expect_rd(2'd2, 32'd2, "tmo_first_rise");
    wave(100, 400, 1, -1, 32'd0);
    expect_rd(2'd2, 32'd3, "tmo_restore");
    wr(2'd2, 32'h2);
    expect_rd(2'd2, 32'd1, "tmo_w1c");
    wr(2'd3, 32'd0);
    poll(1500);
    expect_rd(2'd2, 32'd1, "tmo_disabled");

    pwm = 1'b1;
    poll(50);
    rst = 1'b1;
    poll(2);
    pwm = 1'b0;
    poll(3);
    rst = 1'b0;
    expect_rd(2'd2, 32'd0, "rst2_status");
    expect_rd(2'd3, TRST, "rst2_timeout");
    expect_rd(2'd0, 32'd0, "rst2_high");
    wave(200, 799, 1, -1, 32'd0);
    expect_rd(2'd2, 32'd0, "rst2_no_latch");
    wave(200, 100, 1, -1, 32'd0);
    expect_rd(2'd0, 32'd200, "rst2_high_time");
    expect_rd(2'd1, 32'd1000, "rst2_period");
    expect_rd(2'd2, 32'd1, "rst2_valid");

`ifdef PWM_CAPTURE_IRQ_EN
    wr(2'd2, 32'h100);
    wave(50, 150, 3, -1, 32'd0);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_set: got %b want 1", irq);
    end
    wr(2'd2, 32'h101);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_hold: got %b want 1", irq);
    end
    poll(1);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_fall: got %b want 0", irq);
    end
`endif

    poll(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
